// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: register-zero constant,
// hazard FSM encoding and the shadow destination entry.
package id_hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] r;
  } shadow_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage instruction info flowing into the hazard controller and the
// pipeline control it returns.
interface id_hazard_ctrl_if;
  logic       ID_Valid;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_RegWrite;
  logic [4:0] ID_WReg;
  logic       EXE_BranchTaken;
  logic       ID_shouldstall;
  logic       PC_WriteEn;
  logic       IFID_WriteEn;
  logic       IFID_Flush;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_WReg,
           EXE_BranchTaken,
    input  ID_shouldstall, PC_WriteEn, IFID_WriteEn, IFID_Flush
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_WReg,
           EXE_BranchTaken,
    output ID_shouldstall, PC_WriteEn, IFID_WriteEn, IFID_Flush
  );
endinterface

// File: rtl/id_hazard_ctrl_dst_track.sv
// Shadow pipeline of in-flight destination registers (EXE, MEM, WB) and the
// source-vs-destination compare for the two ID source operands.
module hazard_dst_track
  import id_hazard_ctrl_pkg::*;
#(
  parameter bit CHECK_WB = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  shadow_t    i_load,
  input  logic [4:0] i_src_a,
  input  logic [4:0] i_src_b,
  output logic       o_match_a,
  output logic       o_match_b
);

  shadow_t r_e1;
  shadow_t r_e2;
  shadow_t r_e3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e1 <= '0;
      r_e2 <= '0;
      r_e3 <= '0;
    end else begin
      r_e3 <= r_e2;
      r_e2 <= r_e1;
      r_e1 <= i_load;
    end
  end

  function automatic logic hit(input shadow_t e, input logic [4:0] s);
    return e.v && (e.r == s);
  endfunction

  function automatic logic match(input logic [4:0] s);
    return (s != REG_ZERO) &&
           (hit(r_e1, s) || hit(r_e2, s) || (CHECK_WB && hit(r_e3, s)));
  endfunction

  always_comb begin
    o_match_a = match(i_src_a);
    o_match_b = match(i_src_b);
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Stall-only hazard controller: RAW/load-use stalls, taken-branch IF/ID flush,
// PC and IF/ID write enables, and stall/flush performance counters.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter bit          CHECK_WB = 1'b0,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned EPI_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_hazard_ctrl_if.slave  hz,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic [EPI_W-1:0] stall_episodes
);

  logic       w_match_rs;
  logic       w_match_rt;
  logic       w_raw;
  logic       w_stall_raw;
  shadow_t    w_load;
  hz_state_e  r_state;
  hz_state_e  w_state_nxt;

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_cycles;
  logic [EPI_W-1:0] r_stall_episodes;

  // Bubbles (and squashed wrong-path instructions) must never enter the shadow pipe.
  always_comb begin
    w_load.v = hz.ID_Valid && hz.ID_RegWrite && (hz.ID_WReg != REG_ZERO) &&
               !hz.ID_shouldstall;
    w_load.r = hz.ID_WReg;
  end

  hazard_dst_track #(
    .CHECK_WB (CHECK_WB)
  ) u_track (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_src_a   (hz.ID_Rs),
    .i_src_b   (hz.ID_Rt),
    .o_match_a (w_match_rs),
    .o_match_b (w_match_rt)
  );

  always_comb begin
    w_raw       = hz.ID_Valid && ((hz.ID_UseRs && w_match_rs) ||
                                  (hz.ID_UseRt && w_match_rt));
    w_stall_raw = w_raw && !hz.EXE_BranchTaken;
  end

  always_comb begin
    hz.ID_shouldstall = 1'b0;
    hz.PC_WriteEn     = 1'b1;
    hz.IFID_WriteEn   = 1'b1;
    hz.IFID_Flush     = 1'b0;
    if (hz.EXE_BranchTaken) begin
      hz.ID_shouldstall = 1'b1;
      hz.IFID_Flush     = 1'b1;
    end else if (w_raw) begin
      hz.ID_shouldstall = 1'b1;
      hz.PC_WriteEn     = 1'b0;
      hz.IFID_WriteEn   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_stall_raw)  w_state_nxt = STALL;
      STALL:   if (!w_stall_raw) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles   <= '0;
      r_flush_cycles   <= '0;
      r_stall_episodes <= '0;
    end else begin
      if (w_stall_raw)         r_stall_cycles <= r_stall_cycles + 1'b1;
      if (hz.EXE_BranchTaken)  r_flush_cycles <= r_flush_cycles + 1'b1;
      if ((r_state == RUN) && (w_state_nxt == STALL) && (r_stall_episodes != '1))
        r_stall_episodes <= r_stall_episodes + 1'b1;
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign flush_cycles   = r_flush_cycles;
  assign stall_episodes = r_stall_episodes;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Randomized check of two id_hazard_ctrl instances (EXE/MEM only, and with WB
// check plus narrow counters) against a distance-based in-flight writer model.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_urs = 1'b0, id_urt = 1'b0, id_rw = 1'b0, br = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;

  always #5 clk = ~clk;

  id_hazard_ctrl_if if0 ();
  id_hazard_ctrl_if if1 ();

  assign if0.ID_Valid = id_valid;  assign if1.ID_Valid = id_valid;
  assign if0.ID_Rs = id_rs;        assign if1.ID_Rs = id_rs;
  assign if0.ID_Rt = id_rt;        assign if1.ID_Rt = id_rt;
  assign if0.ID_UseRs = id_urs;    assign if1.ID_UseRs = id_urs;
  assign if0.ID_UseRt = id_urt;    assign if1.ID_UseRt = id_urt;
  assign if0.ID_RegWrite = id_rw;  assign if1.ID_RegWrite = id_rw;
  assign if0.ID_WReg = id_wreg;    assign if1.ID_WReg = id_wreg;
  assign if0.EXE_BranchTaken = br; assign if1.EXE_BranchTaken = br;

  logic [31:0] sc0, fc0;
  logic [15:0] ep0;
  logic [3:0]  sc1, fc1;
  logic [2:0]  ep1;

  id_hazard_ctrl #(.CHECK_WB(1'b0), .CNT_W(32), .EPI_W(16)) dut0 (
    .clk(clk), .rst(rst), .hz(if0.slave),
    .stall_cycles(sc0), .flush_cycles(fc0), .stall_episodes(ep0));

  id_hazard_ctrl #(.CHECK_WB(1'b1), .CNT_W(4), .EPI_W(3)) dut1 (
    .clk(clk), .rst(rst), .hz(if1.slave),
    .stall_cycles(sc1), .flush_cycles(fc1), .stall_episodes(ep1));

  logic [31:0] o_ss [2], o_pc [2], o_ifid [2], o_fl [2], o_sc [2], o_fc [2], o_ep [2];
  assign o_ss[0] = {31'b0, if0.ID_shouldstall};  assign o_ss[1] = {31'b0, if1.ID_shouldstall};
  assign o_pc[0] = {31'b0, if0.PC_WriteEn};      assign o_pc[1] = {31'b0, if1.PC_WriteEn};
  assign o_ifid[0] = {31'b0, if0.IFID_WriteEn};  assign o_ifid[1] = {31'b0, if1.IFID_WriteEn};
  assign o_fl[0] = {31'b0, if0.IFID_Flush};      assign o_fl[1] = {31'b0, if1.IFID_Flush};
  assign o_sc[0] = sc0;                          assign o_sc[1] = {28'b0, sc1};
  assign o_fc[0] = fc0;                          assign o_fc[1] = {28'b0, fc1};
  assign o_ep[0] = {16'b0, ep0};                 assign o_ep[1] = {29'b0, ep1};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: dest[i][k] = register written by the writer k+1 instructions ahead
  // of ID (0 = none); a writer blocks readers while it is fewer than lim[i] ahead.
  int          dest [2][3];
  int unsigned lim  [2] = '{2, 3};
  longint unsigned cnt_mod [2] = '{64'h1_0000_0000, 64'd16};
  int unsigned epi_max [2] = '{65535, 7};
  longint unsigned m_sc [2], m_fc [2];
  int unsigned m_ep [2];
  bit          m_in_stall [2];

  function automatic bit busy(input int i, input int s);
    if (s == 0) return 1'b0;
    for (int k = 0; k < int'(lim[i]); k++) if (dest[i][k] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit raw_of(input int i);
    return id_valid && ((id_urs && busy(i, int'(id_rs))) || (id_urt && busy(i, int'(id_rt))));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) dest[i][k] = 0;
      m_sc[i] = 0; m_fc[i] = 0; m_ep[i] = 0; m_in_stall[i] = 1'b0;
    end
  endtask

  bit last_stall0;

  task automatic step(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urs, input bit urt, input bit rw,
                      input logic [4:0] wr, input bit b);
    bit r [2];
    bit stl [2];
    id_valid = v; id_rs = rs; id_rt = rt; id_urs = urs; id_urt = urt;
    id_rw = rw; id_wreg = wr; br = b;
    #2;
    for (int i = 0; i < 2; i++) begin
      r[i]   = raw_of(i);
      stl[i] = b || r[i];
      chk($sformatf("stall%0d", i), o_ss[i], {31'b0, stl[i]});
      chk($sformatf("pc_we%0d", i), o_pc[i], {31'b0, b || !r[i]});
      chk($sformatf("ifid_we%0d", i), o_ifid[i], {31'b0, b || !r[i]});
      chk($sformatf("flush%0d", i), o_fl[i], {31'b0, b});
      chk($sformatf("stall_cyc%0d", i), o_sc[i], m_sc[i][31:0]);
      chk($sformatf("flush_cyc%0d", i), o_fc[i], m_fc[i][31:0]);
      chk($sformatf("episodes%0d", i), o_ep[i], m_ep[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      dest[i][2] = dest[i][1];
      dest[i][1] = dest[i][0];
      dest[i][0] = (v && rw && !stl[i]) ? int'(wr) : 0;
      if (b) m_fc[i] = (m_fc[i] + 1) % cnt_mod[i];
      if (r[i] && !b) begin
        m_sc[i] = (m_sc[i] + 1) % cnt_mod[i];
        if (!m_in_stall[i] && m_ep[i] < epi_max[i]) m_ep[i]++;
        m_in_stall[i] = 1'b1;
      end else begin
        m_in_stall[i] = 1'b0;
      end
    end
    last_stall0 = r[0] && !b;
    #1;
  endtask

  task automatic async_reset(input bit b);
    br = b;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_stall%0d", i), o_ss[i], {31'b0, b});
      chk($sformatf("rst_pc%0d", i), o_pc[i], 32'd1);
      chk($sformatf("rst_ifid%0d", i), o_ifid[i], 32'd1);
      chk($sformatf("rst_flush%0d", i), o_fl[i], {31'b0, b});
      chk($sformatf("rst_sc%0d", i), o_sc[i], 32'd0);
      chk($sformatf("rst_ep%0d", i), o_ep[i], 32'd0);
    end
    model_reset();
    #1 rst = 1'b0;
  endtask

  logic [4:0] h_rs, h_rt, h_wr;
  bit h_v, h_urs, h_urt, h_rw;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 async_reset(1'b0);
    // load-use on r8
    step(1, 0, 0, 0, 0, 1, 8, 0);
    repeat (4) step(1, 8, 0, 1, 0, 0, 0, 0);
    chk("lu_sc0", sc0, 32'd2);
    chk("lu_ep0", {16'b0, ep0}, 32'd1);
    chk("lu_sc1", {28'b0, sc1}, 32'd3);
    // MEM-distance RAW on Rt=9
    step(1, 0, 0, 0, 0, 1, 9, 0);
    step(1, 0, 0, 0, 0, 1, 3, 0);
    repeat (3) step(1, 0, 9, 0, 1, 0, 0, 0);
    chk("mem_sc0", sc0, 32'd3);
    // r0 writer / unused source
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 5, 0);
    step(1, 5, 5, 0, 0, 0, 0, 0);
    chk("r0_sc0", sc0, 32'd3);
    // branch during pending stall, then reset mid-stall
    step(1, 0, 0, 0, 0, 1, 8, 0);
    step(1, 8, 0, 1, 0, 1, 10, 1);
    step(1, 0, 0, 0, 0, 1, 8, 0);
    step(1, 8, 0, 1, 0, 1, 10, 0);
    async_reset(1'b0);
    step(1, 8, 0, 1, 0, 0, 0, 0);
    // randomized traffic, holding the ID instruction while dut0 stalls
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall0) begin
        h_v = ($urandom_range(9) != 0); h_rs = 5'($urandom_range(7));
        h_rt = 5'($urandom_range(7)); h_urs = $urandom_range(1);
        h_urt = $urandom_range(1); h_rw = ($urandom_range(9) < 7);
        h_wr = 5'($urandom_range(7));
      end
      if ($urandom_range(99) == 0) async_reset(1'($urandom_range(1)));
      step(h_v, h_rs, h_rt, h_urs, h_urt, h_rw, h_wr, $urandom_range(9) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Hazard controller for the 5-stage stall-only (no forwarding) pipeline; the producer of ID_shouldstall, which the ID/EXE latch consumes.
- Keeps its own shadow pipeline of in-flight destination registers (EXE, MEM, optionally WB) and compares it against the ID-stage sources.
- Generates load-use/RAW stalls, the taken-branch flush of IF/ID, PC/IF-ID write enables, and performance counters.

Parameters:
- CHECK_WB, 0, 1 = also stall on a WB-stage match (register file not write-first); 0 = only EXE and MEM are checked
- CNT_W, 32, width of stall_cycles and flush_cycles
- EPI_W, 16, width of stall_episodes

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ID_Valid  in  1  ID stage holds a real instruction
- ID_Rs  in  5  source register A of the ID instruction
- ID_Rt  in  5  source register B of the ID instruction
- ID_UseRs  in  1  ID instruction reads Rs
- ID_UseRt  in  1  ID instruction reads Rt
- ID_RegWrite  in  1  ID instruction writes a register
- ID_WReg  in  5  final destination after the RegDst/Jal mux
- EXE_BranchTaken  in  1  branch/jump resolved taken in EXE this cycle
- ID_shouldstall  out  1  insert a bubble into ID/EXE (combinational)
- PC_WriteEn  out  1  PC may update
- IFID_WriteEn  out  1  IF/ID latch may update
- IFID_Flush  out  1  zero the IF/ID latch
- stall_cycles  out  CNT_W  count of cycles spent in RAW stall
- flush_cycles  out  CNT_W  count of branch-flush cycles
- stall_episodes  out  EPI_W  count of distinct RAW-stall episodes

Behaviour:
- Shadow entries: e1 (EXE), e2 (MEM), e3 (WB). Each entry is {v, r[4:0]}.
- Every edge: e3<=e2; e2<=e1.
- e1 <= {ID_Valid & ID_RegWrite & (ID_WReg!=0) & ~ID_shouldstall, ID_WReg}. A bubble therefore loads v=0.
- match(s) = (s!=0) & ((e1.v & e1.r==s) | (e2.v & e2.r==s) | (CHECK_WB & e3.v & e3.r==s)).
- raw = ID_Valid & ((ID_UseRs & match(ID_Rs)) | (ID_UseRt & match(ID_Rt))).
- Priority: flush > raw.
  - EXE_BranchTaken=1: IFID_Flush=1, ID_shouldstall=1, PC_WriteEn=1, IFID_WriteEn=1. The wrong-path ID instruction is squashed and the raw result is ignored.
  - Else raw=1: ID_shouldstall=1, PC_WriteEn=0, IFID_WriteEn=0, IFID_Flush=0.
  - Else: ID_shouldstall=0, PC_WriteEn=1, IFID_WriteEn=1, IFID_Flush=0.
- All control outputs are combinational from inputs and registered state, with zero latency. They are sampled by the latches on the same edge.
- FSM (state register, 2 states):
  - RUN -> STALL when raw & ~EXE_BranchTaken.
  - STALL -> RUN when no raw, or when EXE_BranchTaken.
  - stall_episodes increments on each RUN->STALL transition and saturates at all-ones.
- stall_cycles increments on every edge where raw & ~EXE_BranchTaken; it wraps modulo 2^CNT_W.
- flush_cycles increments on every edge where EXE_BranchTaken; it wraps modulo 2^CNT_W.
- Stall length without WB check: an EXE match stalls 2 cycles, a MEM match 1 cycle. With CHECK_WB=1, one extra cycle is added for each.
- Register 0 never causes a hazard and is never tracked.
- Simultaneous raw and flush: flush wins, and the cycle is counted only in flush_cycles.
- Reset (async, any time, including mid-stall):
  - e1/e2/e3 v=0, state=RUN, all counters 0.
  - Outputs immediately become ID_shouldstall=EXE_BranchTaken, PC_WriteEn=1, IFID_WriteEn=1, IFID_Flush=EXE_BranchTaken.
- ID_Valid=0: never stalls, and nothing is tracked.

Decomposition:
- Shared pipeline package:
  - REG_ZERO=5'd0
  - hazard FSM state encoding RUN=1'b0, STALL=1'b1
  - shadow-entry typedef {v, r}
- One natural sub-module, hazard_dst_track: the 3-entry shadow shift register plus the match(s) compare, instantiated once with two source ports.
- Counters and FSM stay in the top.

Test Plan:
- Load-use: ID writes r8 (valid) and advances; next cycle ID reads Rs=8. Expect ID_shouldstall=1 and PC_WriteEn=0 for 2 cycles, then release; stall_cycles=2, stall_episodes=1.
- MEM-distance RAW: writer to r9, one independent instruction, then a reader of Rt=9 (UseRt=1). Expect a 1-cycle stall. With CHECK_WB=1, expect 2 cycles.
- r0 and unused-source cases: writer to r0 then reader of r0; and a writer to r5 followed by Rs=5 with UseRs=0. Expect no stall and counters unchanged.
- Branch flush during stall: stall pending on r8 and EXE_BranchTaken=1 in the same cycle. Expect IFID_Flush=1, ID_shouldstall=1, PC_WriteEn=1; flush_cycles=1, stall_cycles not incremented, state=RUN.
- Bubble not tracked: during a stall, the ID instruction (writer to r10) is held. Expect e1.v=0 on the stalled edges, and only one r10 entry enters the shadow pipeline after release.
- Async reset mid-stall: assert rst between edges while stalling. Expect ID_shouldstall=0, PC_WriteEn=1 and counters 0 immediately, with no stall on the next reader of r8.
